// File: rtl/bpsk_tx_scheduler.sv
// Frame scheduler for the BPSK modulator: preamble, FRAME_WORDS codewords MSB first, then an idle gap.
// Define BPSK_DIFF_EN to differentially encode data symbols (DBPSK) against the last preamble symbol.
module bpsk_tx_scheduler #(
    parameter int                 N           = 24,
    parameter int                 SPS         = 4,
    parameter int                 PRE_LEN     = 8,
    parameter logic [PRE_LEN-1:0] PRE_PAT     = 8'hA5,
    parameter int                 FRAME_WORDS = 4,
    parameter int                 GAP_LEN     = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] DataIn,
    input  logic         InValid,
    output logic         InReady,
    output logic         SymOut,
    output logic         SymStrobe,
    output logic         SymActive,
    output logic         FrameStart,
    output logic         FrameDone,
    output logic         Underrun
);
    localparam int TW       = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int CNT_MAX  = (PRE_LEN > N) ? PRE_LEN : N;
    localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int WW       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int GAP_CLKS = GAP_LEN * SPS;
    localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam int GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

    state_t             state, state_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [CW-1:0]      sym_cnt, sym_cnt_nxt;
    logic [WW-1:0]      word_cnt, word_cnt_nxt;
    logic [GW-1:0]      gap_cnt, gap_cnt_nxt;
    logic [N-1:0]       hold_reg, hold_reg_nxt;
    logic [N-1:0]       shift_reg, shift_nxt;
    logic [PRE_LEN-1:0] pre_sr, pre_nxt;
    logic               hold_full, hold_full_nxt;
    logic               sym_out_nxt, strobe_nxt, active_nxt, start_nxt, done_nxt, underrun_nxt;
    logic               timer_last, accept, take, emit_data, data_bit;

    assign accept     = InValid & InReady;
    assign timer_last = (timer == TW'(SPS - 1));

    // NOTE: every variable gets a default at the top of the block, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        sym_cnt_nxt  = sym_cnt;
        word_cnt_nxt = word_cnt;
        gap_cnt_nxt  = gap_cnt;
        shift_nxt    = shift_reg;
        pre_nxt      = pre_sr;
        take         = 1'b0;
        emit_data    = 1'b0;
        data_bit     = 1'b0;
        sym_out_nxt  = SymOut;
        active_nxt   = SymActive;
        strobe_nxt   = 1'b0;
        start_nxt    = 1'b0;
        done_nxt     = 1'b0;
        underrun_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_nxt    = PREAMBLE;
                    timer_nxt    = '0;
                    sym_cnt_nxt  = '0;
                    word_cnt_nxt = '0;
                    pre_nxt      = PRE_PAT;
                    sym_out_nxt  = PRE_PAT[PRE_LEN-1];
                    strobe_nxt   = 1'b1;
                    active_nxt   = 1'b1;
                    start_nxt    = 1'b1;
                end
            end
            PREAMBLE: begin
                if (!timer_last) begin
                    timer_nxt = timer + TW'(1);
                end else begin
                    timer_nxt  = '0;
                    strobe_nxt = 1'b1;
                    if (sym_cnt == CW'(PRE_LEN - 1)) begin
                        state_nxt   = DATA;
                        sym_cnt_nxt = '0;
                        take        = 1'b1;
                        shift_nxt   = hold_reg;
                        emit_data   = 1'b1;
                        data_bit    = hold_reg[N-1];
                    end else begin
                        sym_cnt_nxt = sym_cnt + CW'(1);
                        pre_nxt     = pre_sr << 1;
                        sym_out_nxt = pre_nxt[PRE_LEN-1];
                    end
                end
            end
            DATA: begin
                if (!timer_last) begin
                    timer_nxt = timer + TW'(1);
                end else begin
                    timer_nxt = '0;
                    if (sym_cnt != CW'(N - 1)) begin
                        sym_cnt_nxt = sym_cnt + CW'(1);
                        shift_nxt   = shift_reg << 1;
                        strobe_nxt  = 1'b1;
                        emit_data   = 1'b1;
                        data_bit    = shift_nxt[N-1];
                    end else if (word_cnt == WW'(FRAME_WORDS - 1) || !hold_full) begin
                        // Frame ends here: either complete or starved of its next codeword.
                        done_nxt     = (word_cnt == WW'(FRAME_WORDS - 1));
                        underrun_nxt = (word_cnt != WW'(FRAME_WORDS - 1));
                        active_nxt   = 1'b0;
                        sym_out_nxt  = 1'b0;
                        gap_cnt_nxt  = '0;
                        state_nxt    = (GAP_LEN == 0) ? IDLE : GAP;
                    end else begin
                        take         = 1'b1;
                        shift_nxt    = hold_reg;
                        word_cnt_nxt = word_cnt + WW'(1);
                        sym_cnt_nxt  = '0;
                        strobe_nxt   = 1'b1;
                        emit_data    = 1'b1;
                        data_bit     = hold_reg[N-1];
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_LAST)) state_nxt = IDLE;
                else                          gap_cnt_nxt = gap_cnt + GW'(1);
            end
            default: state_nxt = IDLE;
        endcase

        if (emit_data) begin
`ifdef BPSK_DIFF_EN
            sym_out_nxt = SymOut ^ data_bit;
`else
            sym_out_nxt = data_bit;
`endif
        end

        // Accept only happens while hold is empty and take only while it is full, so they never collide.
        hold_full_nxt = accept | (hold_full & ~take);
        hold_reg_nxt  = accept ? DataIn : hold_reg;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data registers are reset as well, giving a fully defined state after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            timer      <= '0;
            sym_cnt    <= '0;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            hold_reg   <= '0;
            hold_full  <= 1'b0;
            shift_reg  <= '0;
            pre_sr     <= '0;
            InReady    <= 1'b0;
            SymOut     <= 1'b0;
            SymStrobe  <= 1'b0;
            SymActive  <= 1'b0;
            FrameStart <= 1'b0;
            FrameDone  <= 1'b0;
            Underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            sym_cnt    <= sym_cnt_nxt;
            word_cnt   <= word_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            hold_reg   <= hold_reg_nxt;
            hold_full  <= hold_full_nxt;
            shift_reg  <= shift_nxt;
            pre_sr     <= pre_nxt;
            InReady    <= ~hold_full_nxt;
            SymOut     <= sym_out_nxt;
            SymStrobe  <= strobe_nxt;
            SymActive  <= active_nxt;
            FrameStart <= start_nxt;
            FrameDone  <= done_nxt;
            Underrun   <= underrun_nxt;
        end
    end
endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Testbench for bpsk_tx_scheduler: randomized codewords checked against a symbol-stream reference model.
// Honours BPSK_DIFF_EN in the model when the build defines it.
`timescale 1ns/1ps
module tb_bpsk_tx_scheduler;
    localparam int         N        = 24;
    localparam int         SPS      = 4;
    localparam int         PRE_LEN  = 8;
    localparam logic [7:0] PRE_PAT  = 8'hA5;
    localparam int         FW       = 2;
    localparam int         GAP_LEN  = 2;
    localparam int         GAP_CLKS = GAP_LEN * SPS;

    typedef logic [N-1:0] word_t;
    typedef word_t word_q_t[$];

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    word_t data_in = '0, data1 = '0;
    logic  in_valid = 1'b0, valid1 = 1'b0;
    logic  in_ready, sym_out, sym_strobe, sym_active, frame_start, frame_done, underrun;
    logic  ready1, sym1, strobe1, active1, start1, done1, under1;

    int checks = 0;
    int errors = 0;
    bit model_syms[$];

    always #5 clk = ~clk;

    bpsk_tx_scheduler #(.N(N), .SPS(SPS), .PRE_LEN(PRE_LEN), .PRE_PAT(PRE_PAT),
                        .FRAME_WORDS(FW), .GAP_LEN(GAP_LEN)) dut (
        .CLK(clk), .RST(rst), .DataIn(data_in), .InValid(in_valid), .InReady(in_ready),
        .SymOut(sym_out), .SymStrobe(sym_strobe), .SymActive(sym_active),
        .FrameStart(frame_start), .FrameDone(frame_done), .Underrun(underrun));

    bpsk_tx_scheduler #(.N(N), .SPS(1), .PRE_LEN(PRE_LEN), .PRE_PAT(PRE_PAT),
                        .FRAME_WORDS(FW), .GAP_LEN(0)) dut1 (
        .CLK(clk), .RST(rst), .DataIn(data1), .InValid(valid1), .InReady(ready1),
        .SymOut(sym1), .SymStrobe(strobe1), .SymActive(active1),
        .FrameStart(start1), .FrameDone(done1), .Underrun(under1));

    // Reference: symbol sequence of one frame = preamble MSB first, then every word MSB first.
    task automatic build_syms(input word_q_t words);
        logic [PRE_LEN-1:0] pat;
        word_t w;
`ifdef BPSK_DIFF_EN
        bit prev;
`endif
        pat = PRE_PAT;
        model_syms = {};
        for (int i = PRE_LEN - 1; i >= 0; i--) model_syms.push_back(pat[i]);
`ifdef BPSK_DIFF_EN
        prev = pat[0];
`endif
        foreach (words[k]) begin
            w = words[k];
            for (int b = N - 1; b >= 0; b--) begin
`ifdef BPSK_DIFF_EN
                prev = prev ^ w[b];
                model_syms.push_back(prev);
`else
                model_syms.push_back(w[b]);
`endif
            end
        end
    endtask

    task automatic feed(input word_q_t words, input int max_gap);
        int n;
        @(negedge clk);
        foreach (words[i]) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            in_valid = 1'b1;
            data_in  = words[i];
            n = 0;
            while (!in_ready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!in_ready) begin
                errors++;
                $display("FAIL feed_timeout: word %0d InReady=%b, expected 1 within 1000 clocks", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Checks one frame clock by clock from FrameStart through the end of the gap.
    task automatic check_frame(input word_q_t words, input int exact_wait);
        bit         syms[$];
        bit         exp_done;
        int         len, waited;
        logic [5:0] exp_v, act_v;
        build_syms(words);
        syms     = model_syms;
        exp_done = (words.size() == FW);
        len      = syms.size() * SPS;
        waited   = 0;
        @(negedge clk);
        while (!frame_start && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!frame_start) begin
            errors++;
            $display("FAIL frame_start_timeout: FrameStart=%b after %0d clocks, expected 1", frame_start, waited);
            return;
        end
        if (exact_wait >= 0) begin
            checks++;
            if (waited !== exact_wait) begin
                errors++;
                $display("FAIL frame_start_delay: got %0d clocks, expected %0d", waited, exact_wait);
            end
        end
        for (int t = 0; t <= len + GAP_CLKS; t++) begin
            if (t > 0) @(negedge clk);
            if (t < len)       exp_v = {syms[t / SPS], (t % SPS) == 0, 1'b1, t == 0, 1'b0, 1'b0};
            else if (t == len) exp_v = {4'b0000, exp_done, !exp_done};
            else               exp_v = 6'b000000;
            act_v = {sym_out, sym_strobe, sym_active, frame_start, frame_done, underrun};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL frame_t%0d {sym,strobe,active,start,done,underrun}: got %b expected %b", t, act_v, exp_v);
            end
            if (t <= PRE_LEN * SPS) begin
                checks++;
                if (in_ready !== (t == PRE_LEN * SPS)) begin
                    errors++;
                    $display("FAIL in_ready_t%0d: got %b expected %b", t, in_ready, t == PRE_LEN * SPS);
                end
            end
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if ({in_ready, sym_out, sym_strobe, sym_active, frame_start, frame_done, underrun} !== 7'b1000000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d clocks with activity or InReady low, expected 0", name, bad);
        end
    endtask

    task automatic test_reset();
        logic [6:0] act_v;
        repeat (2) @(negedge clk);
        act_v = {in_ready, sym_out, sym_strobe, sym_active, frame_start, frame_done, underrun};
        checks++;
        if (act_v !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000", act_v);
        end
        rst = 1'b0;
        @(negedge clk);
        act_v = {in_ready, sym_out, sym_strobe, sym_active, frame_start, frame_done, underrun};
        checks++;
        if (act_v !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_release: got %b expected 1000000", act_v);
        end
    endtask

    task automatic test_directed();
        word_q_t q;
        q.push_back(24'hF0F00F);
        q.push_back(24'h123456);
        fork
            feed(q, 0);
            check_frame(q, -1);
        join
    endtask

    task automatic test_patterns();
        word_q_t q;
        q.push_back(24'h000000);
        q.push_back(24'hFFFFFF);
        fork
            feed(q, 2);
            check_frame(q, -1);
        join
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            word_q_t q;
            q.push_back(word_t'($urandom));
            q.push_back(word_t'($urandom));
            fork
                feed(q, 4);
                check_frame(q, -1);
            join
        end
    endtask

    task automatic test_underrun();
        word_q_t q;
        q.push_back(word_t'($urandom));
        fork
            feed(q, 1);
            check_frame(q, -1);
        join
        check_quiet("underrun_idle", 20);
    endtask

    task automatic test_back_to_back();
        word_q_t q, f1, f2;
        for (int i = 0; i < 3; i++) q.push_back(word_t'($urandom));
        f1.push_back(q[0]);
        f1.push_back(q[1]);
        f2.push_back(q[2]);
        fork
            feed(q, 0);
            begin
                check_frame(f1, -1);
                check_frame(f2, 0);
            end
        join
        check_quiet("back_to_back_idle", 10);
    endtask

    task automatic test_reset_midframe();
        word_q_t    q;
        logic [6:0] act_v;
        q.push_back(word_t'($urandom));
        q.push_back(word_t'($urandom));
        fork
            feed(q, 0);
            begin
                int n = 0;
                @(negedge clk);
                while (!frame_start && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (!frame_start) begin
                    errors++;
                    $display("FAIL midframe_start: FrameStart=%b, expected 1", frame_start);
                end
                repeat (100) @(negedge clk);
            end
        join
        #2 rst = 1'b1;
        #1 act_v = {in_ready, sym_out, sym_strobe, sym_active, frame_start, frame_done, underrun};
        checks++;
        if (act_v !== 7'b0) begin
            errors++;
            $display("FAIL midframe_reset_async: got %b expected 0000000", act_v);
        end
        @(negedge clk);
        rst = 1'b0;
        check_quiet("midframe_after_release", 40);
    endtask

    task automatic test_sps1();
        word_q_t q;
        bit      syms[$];
        q.push_back(word_t'($urandom));
        q.push_back(word_t'($urandom));
        build_syms(q);
        syms = model_syms;
        fork
            begin : feeder1
                int n;
                @(negedge clk);
                valid1 = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    data1 = q[i];
                    n = 0;
                    while (!ready1 && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    checks++;
                    if (!ready1) begin
                        errors++;
                        $display("FAIL sps1_feed_timeout: word %0d InReady=%b expected 1", i, ready1);
                    end
                    @(negedge clk);
                end
                valid1 = 1'b0;
            end
            begin : monitor1
                int         w;
                logic [5:0] exp_v, act_v;
                w = 0;
                @(negedge clk);
                while (!start1 && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                checks++;
                if (!start1) begin
                    errors++;
                    $display("FAIL sps1_start_timeout: FrameStart=%b expected 1", start1);
                end else begin
                    for (int t = 0; t <= syms.size(); t++) begin
                        if (t > 0) @(negedge clk);
                        if (t < syms.size()) exp_v = {syms[t], 1'b1, 1'b1, t == 0, 1'b0, 1'b0};
                        else                 exp_v = 6'b000010;
                        act_v = {sym1, strobe1, active1, start1, done1, under1};
                        checks++;
                        if (act_v !== exp_v) begin
                            errors++;
                            $display("FAIL sps1_t%0d {sym,strobe,active,start,done,underrun}: got %b expected %b", t, act_v, exp_v);
                        end
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_directed();
        test_patterns();
        test_random_frames();
        test_underrun();
        test_back_to_back();
        test_reset_midframe();
        test_sps1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
